// File: rtl/scan_fwd_unit.sv
// rtl/scan_fwd_unit.sv - read-after-write forwarding for SCAN LLR storage read ports
module scan_fwd_unit #(
    parameter int P        = 64,
    parameter int Q        = 6,
    parameter int AW       = 9,
    parameter int RD_LAT   = 2,
    parameter int NPORT    = 4,
    parameter int FWD_SAME = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [NPORT-1:0]       rd_en,
    input  logic [NPORT*AW-1:0]    rd_addr,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [P-1:0]           wr_mask,
    input  logic [P*Q-1:0]         wr_data,
    input  logic [NPORT*P*Q-1:0]   mem_data,
    output logic [NPORT-1:0]       rd_valid,
    output logic [NPORT*P*Q-1:0]   rd_data,
    output logic [NPORT*P-1:0]     fwd_mask,
    output logic [15:0]            hazard_cnt
);

    localparam int W = P * Q;
    localparam int L = RD_LAT;
    localparam logic SAME_EN = (FWD_SAME != 0);

    // Stage j of port k holds the read issued j+1 cycles ago; stage L-1 returns this cycle.
    logic           vld      [NPORT][L];
    logic [AW-1:0]  ent_addr [NPORT][L];
    logic [P-1:0]   cap_mask [NPORT][L];
    logic [W-1:0]   cap_data [NPORT][L];

    logic [NPORT-1:0] same_hit;
    logic             any_hit;

    function automatic logic [W-1:0] lane_merge(input logic [W-1:0] base,
                                                input logic [P-1:0] m,
                                                input logic [W-1:0] d);
        logic [W-1:0] r;
        r = base;
        for (int i = 0; i < P; i++) begin
            if (m[i]) r[i*Q +: Q] = d[i*Q +: Q];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NPORT; k++) begin
                for (int j = 0; j < L; j++) begin
                    vld[k][j]      <= 1'b0;
                    ent_addr[k][j] <= '0;
                    cap_mask[k][j] <= '0;
                    cap_data[k][j] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                // A read accepted during a flush survives; only older entries are dropped.
                vld[k][0]      <= rd_en[k];
                ent_addr[k][0] <= rd_addr[k*AW +: AW];
                if (wr_en && (wr_addr == rd_addr[k*AW +: AW])) begin
                    cap_mask[k][0] <= wr_mask;
                    cap_data[k][0] <= lane_merge('0, wr_mask, wr_data);
                end else begin
                    cap_mask[k][0] <= '0;
                    cap_data[k][0] <= '0;
                end
                for (int j = 1; j < L; j++) begin
                    vld[k][j]      <= vld[k][j-1] && !flush;
                    ent_addr[k][j] <= ent_addr[k][j-1];
                    if (wr_en && (wr_addr == ent_addr[k][j-1])) begin
                        cap_mask[k][j] <= cap_mask[k][j-1] | wr_mask;
                        cap_data[k][j] <= lane_merge(cap_data[k][j-1], wr_mask, wr_data);
                    end else begin
                        cap_mask[k][j] <= cap_mask[k][j-1];
                        cap_data[k][j] <= cap_data[k][j-1];
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < NPORT; k++) begin : g_same
        assign same_hit[k] = SAME_EN && wr_en && (wr_addr == ent_addr[k][L-1]);
    end

    // Lane priority on return: same-cycle write, then captured write, then storage.
    always_comb begin
        rd_valid = '0;
        rd_data  = '0;
        fwd_mask = '0;
        any_hit  = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            if (vld[k][L-1]) begin
                rd_valid[k] = 1'b1;
                for (int i = 0; i < P; i++) begin
                    if (same_hit[k] && wr_mask[i]) begin
                        rd_data[(k*P+i)*Q +: Q] = wr_data[i*Q +: Q];
                        fwd_mask[k*P+i]         = 1'b1;
                    end else if (cap_mask[k][L-1][i]) begin
                        rd_data[(k*P+i)*Q +: Q] = cap_data[k][L-1][i*Q +: Q];
                        fwd_mask[k*P+i]         = 1'b1;
                    end else begin
                        rd_data[(k*P+i)*Q +: Q] = mem_data[(k*P+i)*Q +: Q];
                    end
                end
                if (|fwd_mask[k*P +: P]) any_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hazard_cnt <= '0;
        end else if (any_hit && (hazard_cnt != 16'hFFFF)) begin
            hazard_cnt <= hazard_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_scan_fwd_unit.sv
// tb/tb_scan_fwd_unit.sv - self-checking bench for scan_fwd_unit (FWD_SAME=1 and FWD_SAME=0 instances)
module tb_scan_fwd_unit;

    localparam int P = 64, Q = 6, AW = 9, RD_LAT = 2, NPORT = 4;
    localparam int W = P * Q;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, flush, wr_en;
    logic [NPORT-1:0]     rd_en;
    logic [NPORT*AW-1:0]  rd_addr;
    logic [AW-1:0]        wr_addr;
    logic [P-1:0]         wr_mask;
    logic [W-1:0]         wr_data;
    logic [NPORT*W-1:0]   mem_data;

    logic [NPORT-1:0]     rd_valid_s, rd_valid_n;
    logic [NPORT*W-1:0]   rd_data_s, rd_data_n;
    logic [NPORT*P-1:0]   fwd_mask_s, fwd_mask_n;
    logic [15:0]          hazard_cnt_s, hazard_cnt_n;

    int checks = 0;
    int failures = 0;

    scan_fwd_unit #(.P(P), .Q(Q), .AW(AW), .RD_LAT(RD_LAT), .NPORT(NPORT), .FWD_SAME(1)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .mem_data(mem_data), .rd_valid(rd_valid_s), .rd_data(rd_data_s),
        .fwd_mask(fwd_mask_s), .hazard_cnt(hazard_cnt_s));

    scan_fwd_unit #(.P(P), .Q(Q), .AW(AW), .RD_LAT(RD_LAT), .NPORT(NPORT), .FWD_SAME(0)) dut_n (
        .clk(clk), .rst(rst), .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .mem_data(mem_data), .rd_valid(rd_valid_n), .rd_data(rd_data_n),
        .fwd_mask(fwd_mask_n), .hazard_cnt(hazard_cnt_n));

    // Observed outputs of the selected instance (d=0: FWD_SAME=1, d=1: FWD_SAME=0)
    logic [NPORT-1:0]   ov;
    logic [NPORT*W-1:0] od;
    logic [NPORT*P-1:0] ofm;
    logic [15:0]        ohz;

    // Reference storage and history of the last few cycles
    logic [W-1:0]  mem [1 << AW];
    bit            r_iss   [8][NPORT];
    logic [AW-1:0] r_addr  [8][NPORT];
    logic [W-1:0]  r_snap  [8][NPORT];
    bit            r_wen   [8];
    logic [AW-1:0] r_waddr [8];
    logic [P-1:0]  r_wmask [8];
    bit            r_fl    [8];

    task automatic sample(input int d);
        ov  = (d == 0) ? rd_valid_s   : rd_valid_n;
        od  = (d == 0) ? rd_data_s    : rd_data_n;
        ofm = (d == 0) ? fwd_mask_s   : fwd_mask_n;
        ohz = (d == 0) ? hazard_cnt_s : hazard_cnt_n;
    endtask

    function automatic logic [W-1:0] rep(input logic [Q-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < P; i++) r[i*Q +: Q] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < (W + 31) / 32; i++) r = (r << 32) | W'($urandom);
        return r;
    endfunction

    function automatic logic [P-1:0] rand_mask();
        logic [P-1:0] r;
        r = '0;
        for (int i = 0; i < (P + 31) / 32; i++) r = (r << 32) | P'($urandom);
        return r;
    endfunction

    task automatic idle();
        rst = 1'b0; flush = 1'b0; rd_en = '0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0; mem_data = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        rd_en = '1;
        next_cycle();
        next_cycle();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            mem_data = {rand_word(), rand_word(), rand_word(), rand_word()};
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                sample(d);
                checks++;
                if (ov !== '0 || od !== '0 || ofm !== '0 || ohz !== 16'h0) begin
                    failures++;
                    $display("FAIL reset_outputs dut=%0d cyc=%0d valid=%b fwd=%h hz=%h exp zero", d, c, ov, ofm, ohz);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_plain_read();
        do_reset();
        rd_en = 4'b0001; rd_addr[0 +: AW] = 9'h010;
        next_cycle();
        idle();
        @(negedge clk);
        checks++;
        if (rd_valid_s !== '0) begin
            failures++;
            $display("FAIL plain_latency valid=%b exp=0000", rd_valid_s);
        end
        next_cycle();
        mem_data[0 +: W] = rep(6'd5);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d);
            checks++;
            if (ov !== 4'b0001 || od[0 +: W] !== rep(6'd5) || ofm !== '0) begin
                failures++;
                $display("FAIL plain_read dut=%0d valid=%b data=%h fwd=%h exp valid=0001 lanes=5 fwd=0", d, ov, od[0 +: W], ofm);
            end
        end
        next_cycle();
        idle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d);
            checks++;
            if (ohz !== 16'd0) begin
                failures++;
                $display("FAIL plain_hazard dut=%0d got=%0d exp=0", d, ohz);
            end
        end
    endtask

    task automatic test_partial_fwd();
        logic [W-1:0]       e;
        logic [NPORT*P-1:0] efm;
        do_reset();
        rd_en = 4'b0010; rd_addr[AW +: AW] = 9'h020;
        next_cycle();
        idle();
        wr_en = 1'b1; wr_addr = 9'h020; wr_mask = 64'hF; wr_data = rep(6'd7);
        next_cycle();
        idle();
        mem_data[W +: W] = rep(6'd3);
        e = rep(6'd3);
        for (int i = 0; i < 4; i++) e[i*Q +: Q] = 6'd7;
        efm = '0; efm[P +: P] = 64'hF;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d);
            checks++;
            if (ov !== 4'b0010 || od[W +: W] !== e || ofm !== efm) begin
                failures++;
                $display("FAIL partial_fwd dut=%0d valid=%b data=%h fwd=%h exp data=%h", d, ov, od[W +: W], ofm, e);
            end
        end
        next_cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d);
            checks++;
            if (ohz !== 16'd1) begin
                failures++;
                $display("FAIL partial_hazard dut=%0d got=%0d exp=1", d, ohz);
            end
        end
    endtask

    task automatic test_newest_wins();
        logic [W-1:0] e;
        do_reset();
        wr_en = 1'b1; wr_addr = 9'h030; wr_mask = '1; wr_data = rep(6'd6);
        next_cycle();
        rd_en = 4'b0001; rd_addr[0 +: AW] = 9'h030;
        wr_mask = 64'h1; wr_data = rep(6'd1);
        next_cycle();
        idle();
        wr_en = 1'b1; wr_addr = 9'h030; wr_mask = 64'h1; wr_data = rep(6'd2);
        next_cycle();
        idle();
        mem_data[0 +: W] = rep(6'd9);
        e = rep(6'd9); e[0 +: Q] = 6'd2;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d);
            checks++;
            if (ov !== 4'b0001 || od[0 +: W] !== e || ofm[0 +: P] !== 64'h1) begin
                failures++;
                $display("FAIL newest_wins dut=%0d data=%h fwd=%h exp data=%h fwd=1", d, od[0 +: W], ofm[0 +: P], e);
            end
        end
    endtask

    task automatic test_fwd_same();
        do_reset();
        rd_en = 4'b1000; rd_addr[3*AW +: AW] = 9'h040;
        next_cycle();
        idle();
        next_cycle();
        wr_en = 1'b1; wr_addr = 9'h040; wr_mask = '1; wr_data = rep(6'd4);
        mem_data[3*W +: W] = rep(6'd8);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d);
            checks++;
            if (ov !== 4'b1000 || od[3*W +: W] !== ((d == 0) ? rep(6'd4) : rep(6'd8))
                || ofm[3*P +: P] !== ((d == 0) ? {P{1'b1}} : {P{1'b0}})) begin
                failures++;
                $display("FAIL fwd_same dut=%0d valid=%b data=%h fwd=%h", d, ov, od[3*W +: W], ofm[3*P +: P]);
            end
        end
        next_cycle();
        idle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d);
            checks++;
            if (ohz !== ((d == 0) ? 16'd1 : 16'd0)) begin
                failures++;
                $display("FAIL fwd_same_hazard dut=%0d got=%0d", d, ohz);
            end
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] e;
        do_reset();
        rd_en = 4'b0100; rd_addr[2*AW +: AW] = 9'h050;
        next_cycle();
        rd_addr[2*AW +: AW] = 9'h051; flush = 1'b1;
        wr_en = 1'b1; wr_addr = 9'h051; wr_mask = 64'h3; wr_data = rep(6'd11);
        next_cycle();
        idle();
        mem_data[2*W +: W] = rep(6'd1);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d);
            checks++;
            if (ov !== '0 || od !== '0 || ofm !== '0) begin
                failures++;
                $display("FAIL flush_drop dut=%0d valid=%b exp=0000", d, ov);
            end
        end
        next_cycle();
        mem_data[2*W +: W] = rep(6'd2);
        e = rep(6'd2); e[0 +: Q] = 6'd11; e[Q +: Q] = 6'd11;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d);
            checks++;
            if (ov !== 4'b0100 || od[2*W +: W] !== e || ofm[2*P +: P] !== 64'h3) begin
                failures++;
                $display("FAIL flush_keep dut=%0d valid=%b data=%h fwd=%h exp data=%h fwd=3", d, ov, od[2*W +: W], ofm[2*P +: P], e);
            end
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        rd_en = '1; rd_addr = {9'h064, 9'h063, 9'h062, 9'h061};
        next_cycle();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 9'h061; wr_mask = '1; wr_data = rep(6'd3);
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            idle();
            mem_data = {rand_word(), rand_word(), rand_word(), rand_word()};
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                sample(d);
                checks++;
                if (ov !== '0 || od !== '0 || ofm !== '0 || ohz !== 16'd0) begin
                    failures++;
                    $display("FAIL reset_inflight dut=%0d cyc=%0d valid=%b fwd=%h hz=%0d exp zero", d, c, ov, ofm, ohz);
                end
            end
            next_cycle();
        end
    endtask

    // Randomised traffic against a storage model: a returned word must equal the storage
    // contents as of the latest visible write, independent of the stale mem_data supplied.
    task automatic run_model(input int ncyc, input bit sat);
        logic [NPORT-1:0]   ev;
        logic [NPORT*W-1:0] ed_s, ed_n;
        logic [NPORT*P-1:0] ef_s, ef_n;
        logic [AW-1:0]      a;
        logic [P-1:0]       fm;
        int                 hz_s, hz_n, s, ts;
        bit                 alive, hit_s, hit_n;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            r_wen[i] = 0; r_fl[i] = 0;
            for (int k = 0; k < NPORT; k++) r_iss[i][k] = 0;
        end
        for (int i = 0; i < (1 << AW); i++) mem[i] = rand_word();
        hz_s = 0; hz_n = 0; ts = 0;
        for (int c = 0; c < ncyc; c++) begin
            s = c % 8;
            flush = !sat && ($urandom_range(0, 19) == 0);
            for (int k = 0; k < NPORT; k++) begin
                rd_en[k] = sat || ($urandom_range(0, 3) != 0);
                rd_addr[k*AW +: AW] = AW'(32'h100 + $urandom_range(0, 3));
            end
            wr_en   = sat || ($urandom_range(0, 9) < 7);
            wr_addr = sat ? rd_addr[0 +: AW] : AW'(32'h100 + $urandom_range(0, 3));
            wr_mask = rand_mask();
            if (sat) wr_mask[0] = 1'b1;
            wr_data = rand_word();
            r_fl[s] = flush; r_wen[s] = wr_en; r_waddr[s] = wr_addr; r_wmask[s] = wr_mask;
            for (int k = 0; k < NPORT; k++) begin
                r_iss[s][k]  = rd_en[k];
                r_addr[s][k] = rd_addr[k*AW +: AW];
                r_snap[s][k] = mem[rd_addr[k*AW +: AW]];
            end
            ev = '0; ed_s = '0; ed_n = '0; ef_s = '0; ef_n = '0;
            for (int k = 0; k < NPORT; k++) begin
                alive = 0;
                if (c >= RD_LAT) begin
                    ts = (c - RD_LAT) % 8;
                    alive = r_iss[ts][k];
                    for (int f = c - RD_LAT + 1; f < c; f++) if (r_fl[f % 8]) alive = 0;
                end
                mem_data[k*W +: W] = alive ? r_snap[ts][k] : rand_word();
                if (alive) begin
                    a = r_addr[ts][k];
                    fm = '0;
                    for (int w = c - RD_LAT; w < c; w++)
                        if (r_wen[w % 8] && r_waddr[w % 8] == a) fm |= r_wmask[w % 8];
                    ev[k] = 1'b1;
                    ed_n[k*W +: W] = mem[a];
                    ed_s[k*W +: W] = mem[a];
                    ef_n[k*P +: P] = fm;
                    ef_s[k*P +: P] = fm;
                    if (wr_en && wr_addr == a) begin
                        ef_s[k*P +: P] = fm | wr_mask;
                        for (int i = 0; i < P; i++)
                            if (wr_mask[i]) ed_s[(k*P+i)*Q +: Q] = wr_data[i*Q +: Q];
                    end
                end
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                sample(d);
                checks++;
                if (ohz !== 16'((d == 0) ? hz_s : hz_n)) begin
                    failures++;
                    $display("FAIL model_hazard dut=%0d cyc=%0d got=%0d exp=%0d", d, c, ohz, (d == 0) ? hz_s : hz_n);
                end
                checks++;
                if (ov !== ev || ofm !== ((d == 0) ? ef_s : ef_n)) begin
                    failures++;
                    $display("FAIL model_valid_fwd dut=%0d cyc=%0d valid=%b exp=%b fwd=%h exp=%h",
                             d, c, ov, ev, ofm, (d == 0) ? ef_s : ef_n);
                end
                for (int k = 0; k < NPORT; k++) begin
                    checks++;
                    if (od[k*W +: W] !== ((d == 0) ? ed_s[k*W +: W] : ed_n[k*W +: W])) begin
                        failures++;
                        $display("FAIL model_data dut=%0d cyc=%0d port=%0d got=%h exp=%h",
                                 d, c, k, od[k*W +: W], (d == 0) ? ed_s[k*W +: W] : ed_n[k*W +: W]);
                    end
                end
            end
            hit_s = 0; hit_n = 0;
            for (int k = 0; k < NPORT; k++) begin
                if (ev[k] && ef_s[k*P +: P] != '0) hit_s = 1;
                if (ev[k] && ef_n[k*P +: P] != '0) hit_n = 1;
            end
            if (hit_s && hz_s < 65535) hz_s++;
            if (hit_n && hz_n < 65535) hz_n++;
            if (wr_en)
                for (int i = 0; i < P; i++)
                    if (wr_mask[i]) mem[wr_addr][i*Q +: Q] = wr_data[i*Q +: Q];
            next_cycle();
        end
        idle();
    endtask

    task automatic test_back_to_back();
        run_model(3000, 1'b0);
    endtask

    task automatic test_saturation();
        run_model(70000, 1'b1);
        @(negedge clk);
        checks++;
        if (hazard_cnt_s !== 16'hFFFF || hazard_cnt_n !== 16'hFFFF) begin
            failures++;
            $display("FAIL hazard_saturate got_s=%h got_n=%h exp=ffff", hazard_cnt_s, hazard_cnt_n);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_plain_read();
        test_partial_fwd();
        test_newest_wins();
        test_fwd_same();
        test_flush();
        test_reset_inflight();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
